// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite types for the arbiter slice: default widths, packed payload widths,
// response code and the arbiter FSM encoding.
package axi4lite_pkg;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int AXI_AW_W   = DEF_ADDR_W + 3;
  localparam int AXI_W_W    = DEF_DATA_W / 8 + DEF_DATA_W;
  localparam int AXI_R_W    = DEF_DATA_W + 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} arb_state_t;
endpackage

// File: rtl/axi4lite_arb_sel.sv
// Combinational winner selection; AXI4LITE_ARB_RR_EN gives round-robin on ties,
// otherwise master 0 has fixed priority.
module axi4lite_arb_sel (
  input  logic [1:0] request,
  input  logic       rr_ptr,
  output logic       grant_valid,
  output logic       grant_id
);
  assign grant_valid = |request;

`ifdef AXI4LITE_ARB_RR_EN
  assign grant_id = (&request) ? rr_ptr : request[1];
`else
  // Pointer only matters for round-robin; keep the port so both builds share the top.
  logic sel_unused;
  assign sel_unused = rr_ptr;
  assign grant_id   = ~request[0];
`endif
endmodule

// File: rtl/axi4lite_arbiter_2to1.sv
// 2:1 AXI4-Lite arbiter, one transaction in flight; AXI4LITE_ARB_RR_EN selects round-robin ties.
// Grant one cycle after request, zero-cycle combinational forwarding; backpressure passes straight through.
module axi4lite_arbiter_2to1
  import axi4lite_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [1:0][ADDR_W+3-1:0]      m_AW,
  input  logic [1:0]                    m_AWVALID,
  output logic [1:0]                    m_AWREADY,
  input  logic [1:0][DATA_W/8+DATA_W-1:0] m_W,
  input  logic [1:0]                    m_WVALID,
  output logic [1:0]                    m_WREADY,
  output logic [1:0][1:0]               m_B,
  output logic [1:0]                    m_BVALID,
  input  logic [1:0]                    m_BREADY,
  input  logic [1:0][ADDR_W+3-1:0]      m_AR,
  input  logic [1:0]                    m_ARVALID,
  output logic [1:0]                    m_ARREADY,
  output logic [1:0][DATA_W+2-1:0]      m_R,
  output logic [1:0]                    m_RVALID,
  input  logic [1:0]                    m_RREADY,
  output logic [ADDR_W+3-1:0]           s_AW,
  output logic                          s_AWVALID,
  input  logic                          s_AWREADY,
  output logic [DATA_W/8+DATA_W-1:0]    s_W,
  output logic                          s_WVALID,
  input  logic                          s_WREADY,
  input  logic [1:0]                    s_B,
  input  logic                          s_BVALID,
  output logic                          s_BREADY,
  output logic [ADDR_W+3-1:0]           s_AR,
  output logic                          s_ARVALID,
  input  logic                          s_ARREADY,
  input  logic [DATA_W+2-1:0]           s_R,
  input  logic                          s_RVALID,
  output logic                          s_RREADY,
  output logic                          busy,
  output logic                          grant_id
);
  arb_state_t state_q, state_d;
  logic       grant_q, grant_d;
  logic       aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic       rr_ptr;
  logic       sel_vld, sel_id;
  logic [1:0] request;
  logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign request = m_AWVALID | m_ARVALID;

`ifdef AXI4LITE_ARB_RR_EN
  logic rr_ptr_q, rr_ptr_d;
  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = 1'b0;
`endif

  axi4lite_arb_sel u_sel (
    .request    (request),
    .rr_ptr     (rr_ptr),
    .grant_valid(sel_vld),
    .grant_id   (sel_id)
  );

  // Handshakes as the slave sees them, i.e. after the done-flag masking.
  assign aw_hs = (state_q == WR_REQ)  & m_AWVALID[grant_q] & ~aw_done_q & s_AWREADY;
  assign w_hs  = (state_q == WR_REQ)  & m_WVALID[grant_q]  & ~w_done_q  & s_WREADY;
  assign b_hs  = (state_q == WR_RESP) & s_BVALID & m_BREADY[grant_q];
  assign ar_hs = (state_q == RD_REQ)  & m_ARVALID[grant_q] & s_ARREADY;
  assign r_hs  = (state_q == RD_RESP) & s_RVALID & m_RREADY[grant_q];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef AXI4LITE_ARB_RR_EN
      rr_ptr_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifdef AXI4LITE_ARB_RR_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    aw_done_d = aw_done_q | aw_hs;
    w_done_d  = w_done_q | w_hs;
`ifdef AXI4LITE_ARB_RR_EN
    rr_ptr_d  = rr_ptr_q;
    if (b_hs || r_hs) rr_ptr_d = ~grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          grant_d = sel_id;
          state_d = m_AWVALID[sel_id] ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        if (aw_done_d && w_done_d) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_RESP: if (b_hs)  state_d = IDLE;
      RD_REQ:  if (ar_hs) state_d = RD_RESP;
      RD_RESP: if (r_hs)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_AWREADY = '0;
    m_WREADY  = '0;
    m_B       = '0;
    m_BVALID  = '0;
    m_ARREADY = '0;
    m_R       = '0;
    m_RVALID  = '0;
    s_AW      = '0;
    s_AWVALID = 1'b0;
    s_W       = '0;
    s_WVALID  = 1'b0;
    s_BREADY  = 1'b0;
    s_AR      = '0;
    s_ARVALID = 1'b0;
    s_RREADY  = 1'b0;
    case (state_q)
      WR_REQ: begin
        s_AW               = m_AW[grant_q];
        s_AWVALID          = m_AWVALID[grant_q] & ~aw_done_q;
        m_AWREADY[grant_q] = s_AWREADY & ~aw_done_q;
        s_W                = m_W[grant_q];
        s_WVALID           = m_WVALID[grant_q] & ~w_done_q;
        m_WREADY[grant_q]  = s_WREADY & ~w_done_q;
      end
      WR_RESP: begin
        m_B[grant_q]      = s_B;
        m_BVALID[grant_q] = s_BVALID;
        s_BREADY          = m_BREADY[grant_q];
      end
      RD_REQ: begin
        s_AR               = m_AR[grant_q];
        s_ARVALID          = m_ARVALID[grant_q];
        m_ARREADY[grant_q] = s_ARREADY;
      end
      RD_RESP: begin
        m_R[grant_q]      = s_R;
        m_RVALID[grant_q] = s_RVALID;
        s_RREADY          = m_RREADY[grant_q];
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;
endmodule

// File: tb/tb_axi4lite_arbiter_2to1.sv
// Directed bench: two bus-functional masters and a small register-file slave around the arbiter.
module tb_axi4lite_arbiter_2to1;
  import axi4lite_pkg::*;

  localparam int AW = AXI_AW_W;
  localparam int WW = AXI_W_W;
  localparam int RW = AXI_R_W;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [1:0][AW-1:0] m_AW;
  logic [1:0]         m_AWVALID, m_AWREADY;
  logic [1:0][WW-1:0] m_W;
  logic [1:0]         m_WVALID, m_WREADY;
  logic [1:0][1:0]    m_B;
  logic [1:0]         m_BVALID, m_BREADY;
  logic [1:0][AW-1:0] m_AR;
  logic [1:0]         m_ARVALID, m_ARREADY;
  logic [1:0][RW-1:0] m_R;
  logic [1:0]         m_RVALID, m_RREADY;
  logic [AW-1:0]      s_AW, s_AR;
  logic [WW-1:0]      s_W;
  logic [RW-1:0]      s_R;
  logic [1:0]         s_B;
  logic s_AWVALID, s_AWREADY, s_WVALID, s_WREADY, s_BVALID, s_BREADY;
  logic s_ARVALID, s_ARREADY, s_RVALID, s_RREADY, busy, grant_id;

  axi4lite_arbiter_2to1 dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .m_AW(m_AW), .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY),
    .m_W(m_W), .m_WVALID(m_WVALID), .m_WREADY(m_WREADY),
    .m_B(m_B), .m_BVALID(m_BVALID), .m_BREADY(m_BREADY),
    .m_AR(m_AR), .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY),
    .m_R(m_R), .m_RVALID(m_RVALID), .m_RREADY(m_RREADY),
    .s_AW(s_AW), .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY),
    .s_W(s_W), .s_WVALID(s_WVALID), .s_WREADY(s_WREADY),
    .s_B(s_B), .s_BVALID(s_BVALID), .s_BREADY(s_BREADY),
    .s_AR(s_AR), .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY),
    .s_R(s_R), .s_RVALID(s_RVALID), .s_RREADY(s_RREADY),
    .busy(busy), .grant_id(grant_id)
  );

  // ---------------- slave model ----------------
  logic          wrdy;
  logic [AW-1:0] aw_q;
  logic [WW-1:0] w_q;
  logic          aw_pend = 1'b0, w_pend = 1'b0, mem_init = 1'b0;
  logic [31:0]   mem [0:1023];
  int            wr_cnt = 0, dup_cnt = 0;

  assign s_AWREADY = 1'b1;
  assign s_WREADY  = wrdy;
  assign s_ARREADY = ~s_RVALID;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_pend  <= 1'b0;
      w_pend   <= 1'b0;
      s_BVALID <= 1'b0;
      s_B      <= '0;
      s_RVALID <= 1'b0;
      s_R      <= '0;
      if (!mem_init) begin
        for (int i = 0; i < 1024; i++) mem[i] <= '0;
        mem_init <= 1'b1;
      end
    end else begin
      if (s_AWVALID) begin
        if (aw_pend) dup_cnt <= dup_cnt + 1;
        aw_pend <= 1'b1;
        aw_q    <= s_AW;
      end
      if (s_WVALID && s_WREADY) begin
        if (w_pend) dup_cnt <= dup_cnt + 1;
        w_pend <= 1'b1;
        w_q    <= s_W;
      end
      if (aw_pend && w_pend) begin
        for (int b = 0; b < 4; b++)
          if (w_q[32+b]) mem[aw_q[9:0]][8*b +: 8] <= w_q[8*b +: 8];
        wr_cnt   <= wr_cnt + 1;
        aw_pend  <= 1'b0;
        w_pend   <= 1'b0;
        s_BVALID <= 1'b1;
        s_B      <= RESP_OKAY;
      end
      if (s_BVALID && s_BREADY) s_BVALID <= 1'b0;
      if (s_RVALID && s_RREADY) s_RVALID <= 1'b0;
      if (s_ARVALID && s_ARREADY) begin
        s_RVALID <= 1'b1;
        s_R      <= {RESP_OKAY, mem[s_AR[9:0]]};
      end
    end
  end

  // ---------------- monitors ----------------
  int   cyc = 0, idle_run = 0, bv1_cnt = 0, rv0_cnt = 0;
  logic busy_prev = 1'b0;
  bit   glog[$];
  int   gap_log[$];

  always @(posedge ACLK) cyc <= cyc + 1;

  always @(negedge ACLK) begin
    if (busy && !busy_prev) begin
      glog.push_back(grant_id);
      gap_log.push_back(idle_run);
    end
    idle_run  <= busy ? 0 : idle_run + 1;
    busy_prev <= busy;
    if (m_BVALID[1]) bv1_cnt <= bv1_cnt + 1;
    if (m_RVALID[0]) rv0_cnt <= rv0_cnt + 1;
  end

  function automatic int glog_at(input int i);
    return (i < glog.size()) ? int'(glog[i]) : 9;
  endfunction

  function automatic int gap_at(input int i);
    return (i < gap_log.size()) ? gap_log[i] : -1;
  endfunction

  // ---------------- checking ----------------
  int errors = 0, checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- master BFMs ----------------
  task automatic axi_write(input int m, input logic [9:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, input bit wait_b,
                           output logic [1:0] bresp, output int aw_wait);
    int n;
    bit aw_on, w_on, aw_hs, w_hs, got;
    bresp = 2'b11;
    aw_wait = 0;
    m_W[m] = {strb, data};
    m_WVALID[m] = 1'b1;
    repeat (w_lead) @(posedge ACLK);
    if (w_lead > 0) #1;
    m_AW[m] = {3'b000, addr};
    m_AWVALID[m] = 1'b1;
    aw_on = 1'b1;
    w_on = 1'b1;
    n = 0;
    while ((aw_on || w_on) && n < 64) begin
      @(negedge ACLK);
      aw_hs = aw_on && m_AWREADY[m];
      w_hs  = w_on && m_WREADY[m];
      if (aw_on && !aw_hs) aw_wait++;
      @(posedge ACLK);
      #1;
      if (aw_hs) begin m_AWVALID[m] = 1'b0; m_AW[m] = '0; aw_on = 1'b0; end
      if (w_hs)  begin m_WVALID[m] = 1'b0;  m_W[m] = '0;  w_on = 1'b0;  end
      n++;
    end
    check_eq($sformatf("m%0d_wr_req_done", m), {aw_on, w_on}, 2'b00);
    m_AWVALID[m] = 1'b0;
    m_WVALID[m] = 1'b0;
    if (wait_b) begin
      m_BREADY[m] = 1'b1;
      got = 1'b0;
      n = 0;
      while (!got && n < 64) begin
        @(negedge ACLK);
        if (m_BVALID[m]) begin bresp = m_B[m]; got = 1'b1; end
        @(posedge ACLK);
        #1;
        n++;
      end
      m_BREADY[m] = 1'b0;
      check_eq($sformatf("m%0d_b_seen", m), got, 1'b1);
    end
  endtask

  task automatic axi_read(input int m, input logic [9:0] addr, input int rdly,
                          output logic [RW-1:0] rdat, output int ar_cyc, output int r_cyc);
    int n;
    bit done;
    rdat = '1;
    ar_cyc = 0;
    r_cyc = 0;
    m_AR[m] = {3'b000, addr};
    m_ARVALID[m] = 1'b1;
    done = 1'b0;
    n = 0;
    while (!done && n < 64) begin
      @(negedge ACLK);
      if (m_ARREADY[m]) begin done = 1'b1; ar_cyc = cyc; end
      @(posedge ACLK);
      #1;
      n++;
    end
    m_ARVALID[m] = 1'b0;
    m_AR[m] = '0;
    check_eq($sformatf("m%0d_ar_done", m), done, 1'b1);
    n = 0;
    @(negedge ACLK);
    while (!m_RVALID[m] && n < 64) begin
      @(negedge ACLK);
      n++;
    end
    for (int i = 0; i < rdly; i++) begin
      check_eq("stall_s_rvalid", s_RVALID, 1'b1);
      check_eq("stall_other_arready", m_ARREADY[1-m], 1'b0);
      @(negedge ACLK);
    end
    check_eq($sformatf("m%0d_r_seen", m), m_RVALID[m], 1'b1);
    rdat = m_R[m];
    r_cyc = cyc;
    m_RREADY[m] = 1'b1;
    @(posedge ACLK);
    #1;
    m_RREADY[m] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    br0, br1;
    logic [RW-1:0] rd0, rd1;
    logic [3:0]    exp_order;
    int aww0, aww1, ac0, rc0, ac1, rc1, g0, n, bv_snap, rv_snap, wr_snap;
    bit seen;

    m_AW = '0; m_AWVALID = '0; m_W = '0; m_WVALID = '0; m_BREADY = '0;
    m_AR = '0; m_ARVALID = '0; m_RREADY = '0;
    wrdy = 1'b1;

    repeat (2) @(posedge ACLK);
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_grant_id", grant_id, 1'b0);
    check_eq("rst_m_ready", {m_AWREADY, m_WREADY, m_ARREADY}, 6'b0);
    check_eq("rst_s_out", {s_AWVALID, s_WVALID, s_ARVALID, s_BREADY, s_RREADY}, 5'b0);
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;

    // m0 write with W held off by the slave, then m1 reads it back
    bv_snap = bv1_cnt; rv_snap = rv0_cnt; wr_snap = wr_cnt;
    wrdy = 1'b0;
    fork
      axi_write(0, 10'h005, 32'hDEADBEEF, 4'hF, 0, 1'b1, br0, aww0);
      begin repeat (3) @(posedge ACLK); #1; wrdy = 1'b1; end
    join
    check_eq("t1_grant_latency", aww0, 1);
    check_eq("t1_bresp", br0, RESP_OKAY);
    check_eq("t1_one_write", wr_cnt - wr_snap, 1);
    axi_read(1, 10'h005, 0, rd1, ac1, rc1);
    check_eq("t1_m1_rdata", rd1, {2'b00, 32'hDEADBEEF});
    check_eq("t1_m1_no_b", bv1_cnt - bv_snap, 0);
    check_eq("t1_m0_no_r", rv0_cnt - rv_snap, 0);

    // simultaneous writes to the same word
    g0 = glog.size();
    fork
      axi_write(0, 10'h010, 32'h11111111, 4'hF, 0, 1'b1, br0, aww0);
      axi_write(1, 10'h010, 32'h22222222, 4'hF, 0, 1'b1, br1, aww1);
    join
    check_eq("t2_first_grant", glog_at(g0), 0);
    check_eq("t2_second_grant", glog_at(g0 + 1), 1);
    check_eq("t2_final_word", mem[16], 32'h22222222);
    check_eq("t2_m1_bresp", br1, RESP_OKAY);

    // back-to-back ties, two writes per master
`ifdef AXI4LITE_ARB_RR_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b1100;
`endif
    g0 = glog.size();
    fork
      begin
        axi_write(0, 10'h030, 32'h30303030, 4'hF, 0, 1'b1, br0, aww0);
        axi_write(0, 10'h031, 32'h31313131, 4'hF, 0, 1'b1, br0, aww0);
      end
      begin
        axi_write(1, 10'h032, 32'h32323232, 4'hF, 0, 1'b1, br1, aww1);
        axi_write(1, 10'h033, 32'h33333333, 4'hF, 0, 1'b1, br1, aww1);
      end
    join
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("t4_grant%0d", i), glog_at(g0 + i), {31'b0, exp_order[i]});
    for (int i = 1; i < 4; i++)
      check_eq($sformatf("t4_idle_gap%0d", i), gap_at(g0 + i), 1);

    // W presented three cycles ahead of AW, partial strobe
    wr_snap = wr_cnt;
    axi_write(0, 10'h020, 32'h0000A5A5, 4'h3, 3, 1'b1, br0, aww0);
    check_eq("t3_bresp", br0, RESP_OKAY);
    check_eq("t3_one_write", wr_cnt - wr_snap, 1);
    check_eq("t3_word", mem[32], 32'h0000A5A5);

    // m1 stalls R for 5 cycles while m0 waits with a read
    fork
      axi_read(1, 10'h005, 5, rd1, ac1, rc1);
      begin
        repeat (2) @(posedge ACLK);
        #1;
        axi_read(0, 10'h010, 0, rd0, ac0, rc0);
      end
    join
    check_eq("t5_m1_rdata", rd1, {2'b00, 32'hDEADBEEF});
    check_eq("t5_m0_rdata", rd0, {2'b00, 32'h22222222});
    check_eq("t5_m0_after_m1", ac0 > rc1, 1'b1);

    // reset while the slave holds a write response
    axi_write(0, 10'h040, 32'h12345678, 4'hF, 0, 1'b0, br0, aww0);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 16) begin
      @(negedge ACLK);
      seen = s_BVALID;
      n++;
    end
    check_eq("t6_in_wr_resp", {seen, busy}, 2'b11);
    #2;
    ARESETN = 1'b0;
    #1;
    check_eq("t6_rst_busy", busy, 1'b0);
    check_eq("t6_rst_valids", {s_AWVALID, s_WVALID, s_ARVALID, m_BVALID, m_RVALID}, 7'b0);
    @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    g0 = glog.size();
    axi_read(1, 10'h005, 0, rd1, ac1, rc1);
    check_eq("t6_m1_grant", glog_at(g0), 1);
    check_eq("t6_m1_rdata", rd1, {2'b00, 32'hDEADBEEF});

    check_eq("slave_no_dup_beats", dup_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
